// File: rtl/native_vin_pkg.sv
// Shared types and constants for the native video input port.
package native_vin_pkg;

    localparam int unsigned CNT_W = 16;

    localparam logic [1:0] ST_WAIT_SOF = 2'd0;
    localparam logic [1:0] ST_ACTIVE   = 2'd1;
    localparam logic [1:0] ST_DONE     = 2'd2;

    typedef enum logic [1:0] {
        WAIT_SOF = ST_WAIT_SOF,
        ACTIVE   = ST_ACTIVE,
        DONE     = ST_DONE
    } state_e;

    localparam string MODE_ONCE = "ONCE";
    localparam string MODE_LINE = "LINE";
    localparam string FS_ON     = "ON";
    localparam string FS_OFF    = "OFF";
    localparam string VS_HIGH   = "HIGH";
    localparam string VS_LOW    = "LOW";

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/native_edge_det.sv
// One-bit input register with a combinational rise or fall pulse against the live input.
module native_edge_det #(
    parameter bit FALL = 1'b1
) (
    input  logic clock,
    input  logic rst,
    input  logic sig,
    output logic edge_c
);

    logic sig_d;

    always_ff @(posedge clock) begin
        if (rst) sig_d <= 1'b0;
        else     sig_d <= sig;
    end

    assign edge_c = FALL ? (sig_d & ~sig) : (sig & ~sig_d);

endmodule

// File: rtl/native_vin_port.sv
// Native vsync/de video input port: aligned pixel output, frame/line markers
// and line/frame length checking for the VDMA write path.
module native_vin_port
    import native_vin_pkg::*;
#(
    parameter int unsigned DSIZE      = 24,
    parameter string       MODE       = "ONCE",
    parameter string       FRAME_SYNC = "OFF",
    parameter string       VS_ACTIVE  = "HIGH"
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [CNT_W-1:0] vactive,
    input  logic [CNT_W-1:0] hactive,
    input  logic             vsync,
    input  logic             de,
    input  logic [DSIZE-1:0] idata,
    output logic             falign,
    output logic             lalign,
    output logic             ealign,
    output logic             odata_vld,
    output logic [DSIZE-1:0] odata,
    output logic             odata_sof,
    output logic             odata_eol,
    output logic             err_hlen,
    output logic             err_vlen
);

    localparam bit          LINE_MODE = (MODE == MODE_LINE);
    localparam bit          SYNC_ON   = (FRAME_SYNC == FS_ON);
    localparam bit          VS_POS    = (VS_ACTIVE == VS_HIGH);
    localparam int unsigned EXT_W     = CNT_W + 1;
    localparam state_e      RST_STATE = SYNC_ON ? WAIT_SOF : ACTIVE;

    state_e             state;
    state_e             state_nxt;
    logic               vs_act;
    logic               frame_start_c;
    logic               line_end_c;
    logic               de_d;
    logic [DSIZE-1:0]   data_d;
    logic [CNT_W-1:0]   hcnt;
    logic [CNT_W-1:0]   lcnt;
    logic [CNT_W-1:0]   hactive_sh;
    logic [CNT_W-1:0]   vactive_sh;
    logic               have_frame;
    logic               sof_pend;

    logic               pass_c;
    logic               vld_c;
    logic               eol_c;
    logic               count_line_c;
    logic               hlen_bad_c;
    logic               reach_c;
    logic               vlen_bad_c;
    logic [CNT_W-1:0]   lcnt_inc_c;

    // vsync is normalised to active-high so a cleared register never looks like a pulse.
    assign vs_act = VS_POS ? vsync : ~vsync;

    native_edge_det #(.FALL(1'b1)) u_vs_edge (
        .clock (clock),
        .rst   (rst),
        .sig   (vs_act),
        .edge_c(frame_start_c)
    );

    native_edge_det #(.FALL(1'b1)) u_de_edge (
        .clock (clock),
        .rst   (rst),
        .sig   (de),
        .edge_c(line_end_c)
    );

    always_ff @(posedge clock) begin
        if (rst) state <= RST_STATE;
        else     state <= state_nxt;
    end

    // Beat qualification, line/frame checks and next state.
    always_comb begin
        state_nxt    = state;
        pass_c       = (state == ACTIVE) || ((state == DONE) && !SYNC_ON);
        vld_c        = de_d & pass_c;
        eol_c        = line_end_c & pass_c;
        count_line_c = line_end_c & (state != WAIT_SOF) & ~frame_start_c;
        hlen_bad_c   = line_end_c & (state != WAIT_SOF) & (hactive_sh != '0) &
                       ((EXT_W'(hcnt) + EXT_W'(1)) != EXT_W'(hactive_sh));
        lcnt_inc_c   = sat_inc(lcnt);
        reach_c      = count_line_c & (state == ACTIVE) & (vactive_sh != '0) &
                       (lcnt_inc_c == vactive_sh);
        vlen_bad_c   = frame_start_c & have_frame & (vactive_sh != '0) & (lcnt != vactive_sh);
        if (frame_start_c)  state_nxt = ACTIVE;
        else if (reach_c)   state_nxt = DONE;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            de_d       <= 1'b0;
            data_d     <= '0;
            falign     <= 1'b0;
            lalign     <= 1'b0;
            ealign     <= 1'b0;
            odata_vld  <= 1'b0;
            odata      <= '0;
            odata_sof  <= 1'b0;
            odata_eol  <= 1'b0;
            err_hlen   <= 1'b0;
            err_vlen   <= 1'b0;
            hcnt       <= '0;
            lcnt       <= '0;
            hactive_sh <= '0;
            vactive_sh <= '0;
            have_frame <= 1'b0;
            sof_pend   <= 1'b0;
        end else begin
            de_d      <= de;
            data_d    <= idata;
            falign    <= frame_start_c;
            lalign    <= LINE_MODE & eol_c;
            ealign    <= reach_c;
            odata_vld <= vld_c;
            odata_eol <= eol_c;
            odata_sof <= vld_c & sof_pend & ~frame_start_c;
            err_hlen  <= hlen_bad_c;
            err_vlen  <= vlen_bad_c;
            if (vld_c) odata <= data_d;

            // A beat landing on the frame-start edge still belongs to the old frame.
            if (frame_start_c) begin
                hactive_sh <= hactive;
                vactive_sh <= vactive;
                have_frame <= 1'b1;
                sof_pend   <= 1'b1;
            end else if (vld_c) begin
                sof_pend   <= 1'b0;
            end

            if (frame_start_c || line_end_c) hcnt <= '0;
            else if (de_d)                   hcnt <= sat_inc(hcnt);

            if (frame_start_c)     lcnt <= '0;
            else if (count_line_c) lcnt <= lcnt_inc_c;
        end
    end

endmodule

// File: tb/tb_native_vin_port.sv
// Bench for native_vin_port: directed vectors, corner sequences and a random
// frame stream checked against a behavioural model of the port.
module tb_native_vin_port;

    logic        clock = 1'b0;
    logic        rst   = 1'b1;
    logic [15:0] va    = 16'd3;
    logic [15:0] ha    = 16'd4;
    logic        vsync = 1'b0;
    logic        de    = 1'b0;
    logic [7:0]  idata = 8'h00;
    logic        vsync_n;

    logic a_fa, a_la, a_ea, a_vl, a_so, a_eo, a_eh, a_ev;
    logic b_fa, b_la, b_ea, b_vl, b_so, b_eo, b_eh, b_ev;
    logic c_fa, c_la, c_ea, c_vl, c_so, c_eo, c_eh, c_ev;
    logic [7:0]  a_d, b_d, c_d;
    logic [15:0] out_a, out_b, out_c;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;
    assign vsync_n = ~vsync;

    native_vin_port #(.DSIZE(8), .MODE("LINE"), .FRAME_SYNC("ON"), .VS_ACTIVE("HIGH")) dut_a (
        .clock(clock), .rst(rst), .vactive(va), .hactive(ha), .vsync(vsync), .de(de), .idata(idata),
        .falign(a_fa), .lalign(a_la), .ealign(a_ea), .odata_vld(a_vl), .odata(a_d),
        .odata_sof(a_so), .odata_eol(a_eo), .err_hlen(a_eh), .err_vlen(a_ev));

    native_vin_port #(.DSIZE(8), .MODE("ONCE"), .FRAME_SYNC("OFF"), .VS_ACTIVE("HIGH")) dut_b (
        .clock(clock), .rst(rst), .vactive(va), .hactive(ha), .vsync(vsync), .de(de), .idata(idata),
        .falign(b_fa), .lalign(b_la), .ealign(b_ea), .odata_vld(b_vl), .odata(b_d),
        .odata_sof(b_so), .odata_eol(b_eo), .err_hlen(b_eh), .err_vlen(b_ev));

    native_vin_port #(.DSIZE(8), .MODE("LINE"), .FRAME_SYNC("ON"), .VS_ACTIVE("LOW")) dut_c (
        .clock(clock), .rst(rst), .vactive(va), .hactive(ha), .vsync(vsync_n), .de(de), .idata(idata),
        .falign(c_fa), .lalign(c_la), .ealign(c_ea), .odata_vld(c_vl), .odata(c_d),
        .odata_sof(c_so), .odata_eol(c_eo), .err_hlen(c_eh), .err_vlen(c_ev));

    // Flag byte order: falign lalign ealign vld sof eol err_hlen err_vlen, then odata.
    assign out_a = {a_fa, a_la, a_ea, a_vl, a_so, a_eo, a_eh, a_ev, a_d};
    assign out_b = {b_fa, b_la, b_ea, b_vl, b_so, b_eo, b_eh, b_ev, b_d};
    assign out_c = {c_fa, c_la, c_ea, c_vl, c_so, c_eo, c_eh, c_ev, c_d};

    // Model state; index 0 = frame-synced LINE port, index 1 = free-running ONCE port.
    bit         p_vs, p_de;
    logic [7:0] p_data;
    bit         m_sync[2], m_done[2], m_have[2], m_pend[2];
    int         m_pix[2], m_lines[2], m_hsh[2], m_vsh[2];
    logic [7:0] m_data[2];
    logic [7:0] m_flags[2];

    task automatic model_step(input bit r, input bit vs, input bit de_i, input logic [7:0] d,
                              input int ha_i, input int va_i);
        bit fs, le, beat, waiting, pass, vld, eol;
        bit fa, la, ea, so, eh, ev;
        if (r) begin
            p_vs = 0; p_de = 0; p_data = '0;
            for (int c = 0; c < 2; c++) begin
                m_sync[c] = 0; m_done[c] = 0; m_have[c] = 0; m_pend[c] = 0;
                m_pix[c] = 0; m_lines[c] = 0; m_hsh[c] = 0; m_vsh[c] = 0;
                m_data[c] = '0; m_flags[c] = '0;
            end
            return;
        end
        fs   = p_vs && !vs;
        le   = p_de && !de_i;
        beat = p_de;
        for (int c = 0; c < 2; c++) begin
            waiting = (c == 0) && !m_sync[c];
            pass    = (c == 1) || (m_sync[c] && !m_done[c]);
            vld     = beat && pass;
            eol     = le && pass;
            la      = eol && (c == 0);
            so      = vld && m_pend[c] && !fs;
            eh      = le && !waiting && (m_hsh[c] != 0) && (m_pix[c] + 1 != m_hsh[c]);
            fa = 0; ea = 0; ev = 0;
            if (vld) m_data[c] = p_data;
            if (fs) begin
                fa = 1;
                ev = m_have[c] && (m_vsh[c] != 0) && (m_lines[c] != m_vsh[c]);
                m_hsh[c] = ha_i; m_vsh[c] = va_i; m_lines[c] = 0; m_pix[c] = 0;
                m_have[c] = 1; m_sync[c] = 1; m_done[c] = 0; m_pend[c] = 1;
            end else begin
                if (vld) m_pend[c] = 0;
                if (le) begin
                    m_pix[c] = 0;
                    if (!waiting) begin
                        m_lines[c]++;
                        if (!m_done[c] && (m_vsh[c] != 0) && (m_lines[c] == m_vsh[c])) begin
                            ea = 1;
                            m_done[c] = 1;
                        end
                    end
                end else if (beat) begin
                    m_pix[c]++;
                end
            end
            m_flags[c] = {fa, la, ea, vld, so, eol, eh, ev};
        end
        p_vs = vs; p_de = de_i; p_data = d;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, compare all ports #1 later.
    task automatic cycle(input bit r, input bit vs, input bit de_i, input logic [7:0] d);
        rst = r; vsync = vs; de = de_i; idata = d;
        @(posedge clock);
        model_step(r, vs, de_i, d, int'(ha), int'(va));
        #1;
        check("model port A", out_a, {m_flags[0], m_data[0]});
        check("model port C", out_c, {m_flags[0], m_data[0]});
        check("model port B", out_b, {m_flags[1], m_data[1]});
    endtask

    typedef struct packed {
        logic       vs;
        logic       de;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[28];

    initial begin
        int cur_h, cur_v, nl, len;
        bit lead;

        // vsync pulse, 3 lines of 4 pixels, one extra line past vactive, next frame start.
        tbl = '{
            '{1'b1, 1'b0, 8'h00}, '{1'b0, 1'b0, 8'h80}, '{1'b0, 1'b1, 8'h00}, '{1'b0, 1'b1, 8'h18},
            '{1'b0, 1'b1, 8'h10}, '{1'b0, 1'b1, 8'h10}, '{1'b0, 1'b0, 8'h54}, '{1'b0, 1'b0, 8'h00},
            '{1'b0, 1'b1, 8'h00}, '{1'b0, 1'b1, 8'h10}, '{1'b0, 1'b1, 8'h10}, '{1'b0, 1'b1, 8'h10},
            '{1'b0, 1'b0, 8'h54}, '{1'b0, 1'b0, 8'h00}, '{1'b0, 1'b1, 8'h00}, '{1'b0, 1'b1, 8'h10},
            '{1'b0, 1'b1, 8'h10}, '{1'b0, 1'b1, 8'h10}, '{1'b0, 1'b0, 8'h74}, '{1'b0, 1'b0, 8'h00},
            '{1'b0, 1'b1, 8'h00}, '{1'b0, 1'b1, 8'h00}, '{1'b0, 1'b1, 8'h00}, '{1'b0, 1'b1, 8'h00},
            '{1'b0, 1'b0, 8'h00}, '{1'b1, 1'b0, 8'h00}, '{1'b0, 1'b0, 8'h81}, '{1'b0, 1'b0, 8'h00}
        };

        cycle(1, 0, 0, 8'h00);
        cycle(1, 0, 0, 8'h00);
        check("reset port A", out_a, 16'h0000);
        check("reset port B", out_b, 16'h0000);
        check("reset port C", out_c, 16'h0000);

        for (int k = 0; k < 28; k++) begin
            cycle(0, tbl[k].vs, tbl[k].de, 8'(k * 7 + 3));
            check($sformatf("vec %0d flags A", k), {8'h00, out_a[15:8]}, {8'h00, tbl[k].exp});
            check($sformatf("vec %0d flags C", k), {8'h00, out_c[15:8]}, {8'h00, tbl[k].exp});
            if (tbl[k].exp[4])
                check($sformatf("vec %0d odata", k), {8'h00, a_d}, {8'h00, 8'((k - 1) * 7 + 3)});
        end

        // Frame start on the same edge as the last pixel of a 2-pixel line.
        cycle(0, 1, 1, 8'hA0);
        cycle(0, 1, 1, 8'hA1);
        check("simul sof A", {8'h00, out_a[15:8]}, {8'h00, 8'h18});
        check("simul sof data", {8'h00, a_d}, 16'h00A0);
        cycle(0, 0, 0, 8'h00);
        check("simul fs/eol A", {8'h00, out_a[15:8]}, 16'h00D7);
        check("simul fs/eol B", {8'h00, out_b[15:8]}, 16'h0097);
        check("simul last pixel", {8'h00, a_d}, 16'h00A1);
        cycle(0, 0, 0, 8'h00);

        // Reset in mid-line, then a trailing vsync edge (rising on the LOW-polarity port).
        cycle(0, 0, 1, 8'h11);
        cycle(0, 0, 1, 8'h22);
        cycle(1, 0, 1, 8'h33);
        check("midline rst A", out_a, 16'h0000);
        check("midline rst B", out_b, 16'h0000);
        check("midline rst C", out_c, 16'h0000);
        cycle(0, 1, 0, 8'h00);
        check("post rst quiet C", out_c, 16'h0000);
        cycle(0, 1, 0, 8'h00);
        cycle(0, 0, 0, 8'h00);
        check("low pol falign C", {15'd0, c_fa}, 16'h0001);

        // Random frames; pixels before the first vsync must not pass on the synced port.
        cycle(1, 0, 0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, (i < 4), 8'($urandom));
            check("presync vld A", {15'd0, a_vl}, 16'h0000);
        end
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 2) == 0) ha = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 2) == 0) va = 16'($urandom_range(0, 4));
            cur_h = (int'(ha) < 1) ? 1 : int'(ha);
            cur_v = (int'(va) < 1) ? 2 : int'(va);
            nl    = cur_v + int'($urandom_range(0, 2)) - 1;
            lead  = ($urandom_range(0, 3) == 0);
            cycle(0, 1, 0, 8'($urandom));
            cycle(0, 1, lead, 8'($urandom));
            for (int l = 0; l < nl; l++) begin
                len = cur_h + (($urandom_range(0, 4) == 0) ? 1 : 0) - (($urandom_range(0, 4) == 0) ? 1 : 0);
                if (len < 1) len = 1;
                if ($urandom_range(0, 5) == 0) ha = 16'($urandom_range(1, 6));
                for (int p = 0; p < len; p++) cycle(0, 0, 1, 8'($urandom));
                for (int g = 0; g < int'($urandom_range(1, 2)); g++) cycle(0, 0, 0, 8'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/native_vin_port.md
Name: native_vin_port

Overview:
- Parametrised successor to the native video input port of the VDMA write path.
- Takes a native vsync/de/data pixel stream and produces frame-start, line-end and frame-end alignment pulses for the VDMA write path.
- Adds registered, marker-aligned data, per-frame shadowing of geometry, an optional frame-sync gate, and line/frame length error detection.
- Sits between the video source and the write-side FIFO/burst packer.

Parameters:
- DSIZE, 24, pixel data width.
- MODE, "ONCE", "ONCE" means lalign is held 0; "LINE" means lalign pulses on the last pixel of each line.
- FRAME_SYNC, "OFF", "ON" gates data until the first frame start and after vactive lines; "OFF" passes all de beats.
- VS_ACTIVE, "HIGH", vsync pulse polarity; the frame starts at the trailing edge of the pulse (falling for "HIGH", rising for "LOW").

Ports:
- clock  in  1  pixel clock.
- rst  in  1  reset; the block has one clock, and reset is synchronous and active-high.
- vactive  in  16  lines per frame; sampled at frame start.
- hactive  in  16  pixels per line; sampled at frame start.
- vsync  in  1  vertical sync.
- de  in  1  data enable.
- idata  in  DSIZE  pixel data.
- falign  out  1  one-cycle pulse at frame start.
- lalign  out  1  one-cycle pulse coincident with the last pixel of a line (LINE mode only).
- ealign  out  1  one-cycle pulse when the line count reaches the shadowed vactive.
- odata_vld  out  1  output pixel valid.
- odata  out  DSIZE  output pixel.
- odata_sof  out  1  first valid pixel of a frame.
- odata_eol  out  1  last pixel of a line (generated in both modes).
- err_hlen  out  1  one-cycle pulse at line end when pixel count differs from the shadowed hactive.
- err_vlen  out  1  one-cycle pulse at frame start when the previous frame's line count differs from the shadowed vactive.

Behaviour:
- Reset: all outputs, counters, shadows and input registers are 0. State is WAIT_SOF if FRAME_SYNC="ON", otherwise ACTIVE.
- Stage 1: vsync, de and idata are registered.
- Stage 2 (output registers): edges are computed from stage 1 versus the live input.
  - frame start: vs_d active and vsync inactive.
  - line end: de_d=1 and de=0.
- Latency: input to odata/odata_vld is exactly 2 cycles. falign, lalign, odata_eol and err_hlen are aligned with the pixel or cycle they describe.
- odata updates only when a beat is valid; otherwise odata holds its value.
- Counters:
  - hcnt counts valid de beats in the current line and clears at line end.
  - lcnt counts line ends and clears at frame start.
  - Both are 16 bits and saturate at 16'hFFFF (no wrap).
- Frame start:
  - Shadows hactive/vactive.
  - Pulses falign.
  - Evaluates err_vlen against the previous shadow: pulses only if a previous frame exists and lcnt != old vactive.
  - Clears lcnt.
  - Next state is ACTIVE.
  - The next valid pixel carries odata_sof=1.
- Line end:
  - err_hlen pulses if hcnt+1 != hactive_sh.
  - lcnt increments.
  - When the increment makes lcnt equal vactive_sh: ealign pulses once and state becomes DONE.
- States:
  - WAIT_SOF: odata_vld=0; lines are not counted; exit only on frame start.
  - ACTIVE: data passes.
  - DONE: with FRAME_SYNC="ON", odata_vld=0 and extra lines are counted (they feed err_vlen); with "OFF", data passes. Exit on frame start.
- Zero geometry: hactive_sh=0 disables err_hlen; vactive_sh=0 disables ealign, err_vlen and entry to DONE.
- Simultaneous frame start and line end: frame start wins.
  - The line end is not counted.
  - odata_eol and lalign still mark the pixel.
  - err_hlen pulses if hcnt+1 != hactive_sh.
- de still high at frame start: the pixel stream continues, and hcnt clears to count the new line from the next beat.
- rst mid-frame: outputs go to 0 on the next edge and state returns to the reset state; no pulses are generated from pre-reset history, because the input registers are cleared.

Decomposition:
- Package native_vin_pkg:
  - state enum {WAIT_SOF, ACTIVE, DONE};
  - mode/polarity string constants;
  - counter width constant CNT_W=16.
- One sub-module, native_edge_det: registers the input and gives rise/fall pulses with synchronous active-high reset. One instance each for vsync and de.

Test Plan:
- FRAME_SYNC=ON, MODE=LINE, hactive=4, vactive=3, 3 lines of 4 pixels after a vsync pulse:
  - falign once; odata_sof on pixel 0.
  - 3 lalign/odata_eol pulses, each on pixel 3.
  - ealign on the 3rd line end; no errors.
  - odata equals idata delayed 2 cycles.
- FRAME_SYNC=ON, pixels before the first vsync, then a 4th line after vactive=3 is reached: odata_vld=0 for both; err_vlen=1 at the next frame start.
- Line of 5 pixels with hactive=4: err_hlen pulses with odata_eol of pixel 4; MODE=ONCE gives lalign=0 throughout and odata_eol still pulses.
- hactive changed from 4 to 8 mid-frame: no err_hlen in the current frame; 4-pixel lines then flag err_hlen in the next frame.
- Frame start coinciding with de falling:
  - falign=1 and odata_eol=1 on that last pixel.
  - lcnt not incremented.
  - err_hlen=1 if that line was short.
- VS_ACTIVE=LOW, then rst asserted mid-line for 1 cycle: all outputs 0 next cycle; the rising vsync edge then produces falign.
